// File: rtl/cmp_sort_ctrl.sv
// rtl/cmp_sort_ctrl.sv - frame sort engine: load K signed words, bubble-sort on shared comparators, stream out ascending.
// Optional CMP_SORT_STATS_EN adds swap_cnt_o (swaps performed while sorting the current frame).

module comparator_lt #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  output logic                lt_o
);
  assign lt_o = (a_i < b_i);
endmodule

module comparator_eq #(
  parameter int N = 32
) (
  input  logic signed [N-1:0] a_i,
  input  logic signed [N-1:0] b_i,
  output logic                eq_o
);
  assign eq_o = (a_i == b_i);
endmodule

module cmp_sort_ctrl #(
  parameter int N = 32,
  parameter int K = 8,
  localparam int SW = $clog2(K * (K - 1) / 2 + 1)
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] in_data_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] out_data_o,
  output logic         busy_o
`ifdef CMP_SORT_STATS_EN
  ,
  output logic [SW-1:0] swap_cnt_o
`endif
);

  localparam int IW = (K > 1) ? $clog2(K) : 1;

  typedef enum logic [1:0] {
    S_LOAD,
    S_SORT,
    S_OUT
  } state_t;

  state_t          state_q;
  logic [N-1:0]    mem_q [K];
  logic [IW-1:0]   wr_idx_q;
  logic [IW-1:0]   rd_idx_q;
  logic [IW-1:0]   j_q;
  logic [IW-1:0]   pass_q;
  logic            swapped_q;
  logic            in_ready_q;
  logic            out_valid_q;
  logic            busy_q;

  logic [IW-1:0]   j_d;
  logic signed [N-1:0] cmp_a;
  logic signed [N-1:0] cmp_b;
  logic            lt;
  logic            eq;
  logic            do_swap;
  logic            pass_swapped;
  logic            last_j;
  logic            load_done;

  assign j_d   = j_q + 1'b1;
  assign cmp_a = mem_q[j_d];
  assign cmp_b = mem_q[j_q];

  comparator_lt #(.N(N)) u_lt (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .lt_o (lt)
  );

  comparator_eq #(.N(N)) u_eq (
    .a_i  (cmp_a),
    .b_i  (cmp_b),
    .eq_o (eq)
  );

  // Equal neighbours never swap, which keeps the sort stable.
  assign do_swap      = lt & ~eq;
  assign pass_swapped = swapped_q | do_swap;
  assign last_j       = (j_q == IW'(K - 2));
  assign load_done    = (state_q == S_LOAD) && in_valid_i && in_ready_q &&
                        (wr_idx_q == IW'(K - 1));

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= S_LOAD;
      wr_idx_q    <= '0;
      rd_idx_q    <= '0;
      j_q         <= '0;
      pass_q      <= '0;
      swapped_q   <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          if (in_valid_i && in_ready_q) begin
            mem_q[wr_idx_q] <= in_data_i;
            wr_idx_q        <= wr_idx_q + 1'b1;
            if (wr_idx_q == IW'(K - 1)) begin
              state_q    <= S_SORT;
              j_q        <= '0;
              pass_q     <= '0;
              swapped_q  <= 1'b0;
              in_ready_q <= 1'b0;
              busy_q     <= 1'b1;
            end
          end
        end
        S_SORT: begin
          if (do_swap) begin
            mem_q[j_q] <= cmp_a;
            mem_q[j_d] <= cmp_b;
          end
          swapped_q <= pass_swapped;
          if (last_j) begin
            if (!pass_swapped || (pass_q == IW'(K - 2))) begin
              state_q     <= S_OUT;
              rd_idx_q    <= '0;
              busy_q      <= 1'b0;
              out_valid_q <= 1'b1;
            end else begin
              pass_q    <= pass_q + 1'b1;
              j_q       <= '0;
              swapped_q <= 1'b0;
            end
          end else begin
            j_q <= j_d;
          end
        end
        S_OUT: begin
          if (out_ready_i) begin
            rd_idx_q <= rd_idx_q + 1'b1;
            if (rd_idx_q == IW'(K - 1)) begin
              state_q     <= S_LOAD;
              wr_idx_q    <= '0;
              out_valid_q <= 1'b0;
              in_ready_q  <= 1'b1;
            end
          end
        end
        default: begin
          state_q     <= S_LOAD;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          busy_q      <= 1'b0;
        end
      endcase
    end
  end

`ifdef CMP_SORT_STATS_EN
  logic [SW-1:0] swap_cnt_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || load_done) begin
      swap_cnt_q <= '0;
    end else if ((state_q == S_SORT) && do_swap) begin
      swap_cnt_q <= swap_cnt_q + 1'b1;
    end
  end

  assign swap_cnt_o = swap_cnt_q;
`endif

  // Reset forces the handshake outputs low immediately, not one edge later.
  assign in_ready_o  = in_ready_q & ~rst_i;
  assign out_valid_o = out_valid_q & ~rst_i;
  assign busy_o      = busy_q & ~rst_i;
  assign out_data_o  = mem_q[rd_idx_q];

endmodule
